uart_fifo_param: RTL and testbench

UART_FIFO_PARAM -- requirements
Module: uart_fifo_param

---
 rtl/uart_fifo_param.sv | 91 +++++++++
 tb/tb_uart_fifo_param.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_param.sv
// Synchronous FIFO with valid/ready on both sides, occupancy count and almost-full/empty flags.
// Optional flush port is built when UART_FIFO_FLUSH_EN is defined.
module uart_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 64,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4,
  localparam int LW       = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [LW-1:0]    load,
  output logic             almost_full,
  output logic             almost_empty
`ifdef UART_FIFO_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    load_q, load_d;
  logic             push, pop, flush_w;

`ifdef UART_FIFO_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign s_ready      = (load_q != DEPTH_L);
  assign m_valid      = (load_q != '0);
  assign m_data       = mem_q[rd_ptr_q];
  assign load         = load_q;
  assign almost_full  = (load_q >= AFULL_L);
  assign almost_empty = (load_q <= AEMPTY_L);

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    load_d   = load_q;
    if (flush_w) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      load_d   = '0;
    end else begin
      // power-of-two depth: pointers wrap naturally at DEPTH-1
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   load_d = load_q + LW'(1);
        2'b01:   load_d = load_q - LW'(1);
        default: load_d = load_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      load_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      load_q   <= load_d;
    end
  end

  // storage is not reset; writes are suppressed by reset or flush
  always_ff @(posedge clk) begin
    if (rst_n && push && !flush_w) mem_q[wr_ptr_q] <= s_data;
  end

endmodule

// File: tb/tb_uart_fifo_param.sv
// Directed self-checking bench for uart_fifo_param at default parameters (8 x 64, thresholds 60/4).
// Flush scenario is compiled in only when UART_FIFO_FLUSH_EN is defined.
module tb_uart_fifo_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [6:0] load;
  logic       almost_full;
  logic       almost_empty;
`ifdef UART_FIFO_FLUSH_EN
  logic       flush;
`endif

  int n_cmp = 0;
  int n_err = 0;

  uart_fifo_param dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .load         (load),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
`ifdef UART_FIFO_FLUSH_EN
    ,
    .flush        (flush)
`endif
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
`ifdef UART_FIFO_FLUSH_EN
    flush = 1'b0;
`endif
    step(); step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    n_cmp++; if (load !== 7'd0) begin n_err++; $display("FAIL reset_load got %0d want 0", load); end
    n_cmp++; if (almost_empty !== 1'b1) begin n_err++; $display("FAIL reset_aempty got %b want 1", almost_empty); end
    n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL reset_afull got %b want 0", almost_full); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
      n_cmp++; if (load !== 7'(i + 1)) begin n_err++; $display("FAIL fill_load[%0d] got %0d want %0d", i, load, i + 1); end
      n_cmp++; if (almost_full !== ((i + 1) >= 60)) begin n_err++; $display("FAIL fill_afull[%0d] got %b want %b", i, almost_full, (i + 1) >= 60); end
      n_cmp++; if (almost_empty !== ((i + 1) <= 4)) begin n_err++; $display("FAIL fill_aempty[%0d] got %b want %b", i, almost_empty, (i + 1) <= 4); end
    end
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL full_s_ready got %b want 0", s_ready); end
    // offered word while full must be ignored
    s_data = 8'hAA;
    step();
    n_cmp++; if (load !== 7'd64) begin n_err++; $display("FAIL full_hold_load got %0d want 64", load); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'(i)) begin n_err++; $display("FAIL drain_data[%0d] got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, 8'(i)); end
      step();
      n_cmp++; if (load !== 7'(63 - i)) begin n_err++; $display("FAIL drain_load[%0d] got %0d want %0d", i, load, 63 - i); end
    end
    m_ready = 1'b0;
    n_cmp++; if (m_valid !== 1'b0 || s_ready !== 1'b1) begin n_err++; $display("FAIL drain_end got v=%b r=%b want v=0 r=1", m_valid, s_ready); end
  endtask

  task automatic test_zero_latency();
    s_valid = 1'b1; s_data = 8'hFF;
    step();
    s_valid = 1'b0; s_data = 8'h00;
    n_cmp++; if (m_valid !== 1'b1 || m_data !== 8'hFF) begin n_err++; $display("FAIL zl_first got v=%b d=%h want v=1 d=ff", m_valid, m_data); end
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (m_data !== 8'hFF || load !== 7'd1) begin n_err++; $display("FAIL zl_hold[%0d] got d=%h load=%0d want d=ff load=1", i, m_data, load); end
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    n_cmp++; if (load !== 7'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL zl_pop got load=%0d v=%b want 0 0", load, m_valid); end
  endtask

  task automatic test_stream();
    logic [7:0] q[$];
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = 8'(8'hC0 + i); q.push_back(s_data);
      step();
    end
    m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s_data = 8'(i * 7 + 3);
      n_cmp++; if (m_data !== q[0]) begin n_err++; $display("FAIL stream_data[%0d] got %h want %h", i, m_data, q[0]); end
      q.push_back(s_data);
      void'(q.pop_front());
      step();
      n_cmp++; if (load !== 7'd10) begin n_err++; $display("FAIL stream_load[%0d] got %0d want 10", i, load); end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (m_data !== q[0]) begin n_err++; $display("FAIL stream_tail[%0d] got %h want %h", i, m_data, q[0]); end
      void'(q.pop_front());
      step();
    end
    m_ready = 1'b0;
    n_cmp++; if (load !== 7'd0) begin n_err++; $display("FAIL stream_end_load got %0d want 0", load); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 64; i++) begin
      s_valid = 1'b1; s_data = 8'(i * 3);
      step();
    end
    s_data = 8'hEE; m_ready = 1'b1;
    step();
    n_cmp++; if (load !== 7'd63) begin n_err++; $display("FAIL fullpop_load got %0d want 63", load); end
    m_ready = 1'b0;
    step();
    n_cmp++; if (load !== 7'd64) begin n_err++; $display("FAIL fullpop_push got %0d want 64", load); end
    s_valid = 1'b0; m_ready = 1'b1;
    for (int i = 1; i < 64; i++) begin
      n_cmp++; if (m_data !== 8'(i * 3)) begin n_err++; $display("FAIL fullpop_order[%0d] got %h want %h", i, m_data, 8'(i * 3)); end
      step();
    end
    n_cmp++; if (m_data !== 8'hEE || load !== 7'd1) begin n_err++; $display("FAIL fullpop_last got d=%h load=%0d want d=ee load=1", m_data, load); end
    step();
    m_ready = 1'b0;
    n_cmp++; if (load !== 7'd0) begin n_err++; $display("FAIL fullpop_end got %0d want 0", load); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h30 + i);
      step();
    end
    rst_n = 1'b0; s_data = 8'h99; m_ready = 1'b1;
    step();
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    n_cmp++; if (load !== 7'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL midrst got load=%0d v=%b want 0 0", load, m_valid); end
    s_valid = 1'b1; s_data = 8'h5A;
    step();
    s_valid = 1'b0;
    n_cmp++; if (m_data !== 8'h5A || load !== 7'd1) begin n_err++; $display("FAIL midrst_first got d=%h load=%0d want d=5a load=1", m_data, load); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

`ifdef UART_FIFO_FLUSH_EN
  task automatic test_flush();
    for (int i = 0; i < 20; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      step();
    end
    flush = 1'b1; s_data = 8'h77;
    step();
    flush = 1'b0; s_valid = 1'b0;
    n_cmp++; if (load !== 7'd0 || m_valid !== 1'b0) begin n_err++; $display("FAIL flush got load=%0d v=%b want 0 0", load, m_valid); end
    s_valid = 1'b1; s_data = 8'h11;
    step();
    s_valid = 1'b0;
    n_cmp++; if (m_data !== 8'h11 || load !== 7'd1) begin n_err++; $display("FAIL flush_after got d=%h load=%0d want d=11 load=1", m_data, load); end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_fill_drain();
    test_zero_latency();
    test_stream();
    test_full_pop();
    test_reset_midstream();
`ifdef UART_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
